// File: rtl/quad_pkg.sv
// Shared types and the quadrature step decoder for quad_encoder_decoder.
package quad_pkg;

  localparam int POS_W = 32;

  typedef enum logic {SETTLE, RUN} state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ERR} step_t;

  // Position of an {A,B} code along the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_index(input logic [1:0] ab);
    logic [1:0] idx;
    idx = 2'd0;
    case (ab)
      2'b00: idx = 2'd0;
      2'b01: idx = 2'd1;
      2'b11: idx = 2'd2;
      2'b10: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Distance travelled around the cycle: 1 is forward, 3 is reverse, 2 means
  // both bits flipped, which no legal encoder can produce.
  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] curr_ab);
    logic [1:0] delta;
    step_t      step;
    delta = gray_index(curr_ab) - gray_index(prev_ab);
    step  = STEP_NONE;
    case (delta)
      2'd0: step = STEP_NONE;
      2'd1: step = STEP_UP;
      2'd2: step = STEP_ERR;
      2'd3: step = STEP_DOWN;
      default: step = STEP_NONE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser plus persistence filter for one raw encoder pin.
// A new level is accepted only after it has been seen FILTER_CYCLES times in a row.
module quad_input_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  logic       sync_1;
  logic       sync_2;
  logic [7:0] run_cnt;

  // Synchronise the pin, then count consecutive disagreements with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      filtered <= 1'b0;
      run_cnt  <= 8'd0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 != filtered) begin
        if (run_cnt == 8'(FILTER_CYCLES - 1)) begin
          filtered <= sync_2;
          run_cnt  <= 8'd0;
        end else begin
          run_cnt <= run_cnt + 8'd1;
        end
      end else begin
        run_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_decoder.sv
// Quadrature decoder for one motor axis: filtered A/B pins, 4x decode,
// wrapping signed position, sticky illegal-transition flag.
// Optional velocity measurement is built only when QUAD_VELOCITY_EN is defined.
//
// state  | meaning
// SETTLE | filters filling after reset; prev_ab tracks, no counting or errors
// RUN    | decode filt_ab against prev_ab every cycle
module quad_encoder_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter bit DIR_INVERT    = 1'b0,
  parameter int VEL_WINDOW    = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    count_clear,
  output logic signed [POS_W-1:0] position,
  output logic                    step_pulse,
  output logic                    step_dir,
  output logic                    quad_err,
  output logic signed [POS_W-1:0] velocity,
  output logic                    vel_valid
);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("FILTER_CYCLES must be in 1..255");
  end
  if (VEL_WINDOW < 2) begin : g_bad_window
    $error("VEL_WINDOW must be at least 2");
  end

  localparam logic [8:0] SETTLE_LOAD = 9'(FILTER_CYCLES + 2);

  logic       filt_a;
  logic       filt_b;
  logic [1:0] filt_ab;
  logic [1:0] prev_ab;
  logic [8:0] settle_cnt;
  state_t     state;
  state_t     state_next;
  step_t      step;
  logic       count_up;
  logic       count_down;
  logic       err_set;

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
    .clk      (clk),
    .reset    (reset),
    .raw      (enc_a),
    .filtered (filt_a)
  );

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
    .clk      (clk),
    .reset    (reset),
    .raw      (enc_b),
    .filtered (filt_b)
  );

  assign filt_ab = {filt_a, filt_b};
  assign step    = decode_step(prev_ab, filt_ab);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SETTLE;
    else       state <= state_next;
  end

  // Next state and per-cycle count/error decisions.
  always_comb begin
    state_next = state;
    count_up   = 1'b0;
    count_down = 1'b0;
    err_set    = 1'b0;
    case (state)
      SETTLE: if (settle_cnt == 9'd0) state_next = RUN;
      RUN: begin
        count_up   = DIR_INVERT ? (step == STEP_DOWN) : (step == STEP_UP);
        count_down = DIR_INVERT ? (step == STEP_UP)   : (step == STEP_DOWN);
        err_set    = (step == STEP_ERR);
      end
      default: state_next = SETTLE;
    endcase
  end

  // Settle timer, previous-code tracking, position and flags; clear overrides any step.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= SETTLE_LOAD;
      prev_ab    <= 2'b00;
      position   <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      quad_err   <= 1'b0;
    end else begin
      prev_ab    <= filt_ab;
      step_pulse <= 1'b0;
      if (state == SETTLE && settle_cnt != 9'd0) settle_cnt <= settle_cnt - 9'd1;
      if (count_clear) begin
        position <= '0;
        quad_err <= 1'b0;
      end else begin
        if (err_set) quad_err <= 1'b1;
        if (count_up || count_down) begin
          position   <= count_up ? position + 32'sd1 : position - 32'sd1;
          step_pulse <= 1'b1;
          step_dir   <= count_up;
        end
      end
    end
  end

`ifdef QUAD_VELOCITY_EN
  logic [31:0]             win_cnt;
  logic signed [POS_W-1:0] snapshot;

  // Window timer: at each wrap report the position change since the previous wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt   <= 32'd0;
      snapshot  <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (count_clear) begin
        win_cnt  <= 32'd0;
        snapshot <= '0;
      end else if (state == RUN) begin
        if (win_cnt == 32'(VEL_WINDOW - 1)) begin
          win_cnt   <= 32'd0;
          velocity  <= position - snapshot;
          snapshot  <= position;
          vel_valid <= 1'b1;
        end else begin
          win_cnt <= win_cnt + 32'd1;
        end
      end
    end
  end
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Scoreboard bench for quad_encoder_decoder: each issued encoder step pushes the
// expected position/direction; a monitor pops on every step_pulse.
module tb_quad_encoder_decoder;

  localparam int F = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enc_a;
  logic        enc_b;
  logic        count_clear;

  logic [31:0] position, velocity;
  logic        step_pulse, step_dir, quad_err, vel_valid;
  logic [31:0] inv_position, inv_velocity;
  logic        inv_step_pulse, inv_step_dir, inv_quad_err, inv_vel_valid;

  quad_encoder_decoder #(.FILTER_CYCLES(F), .DIR_INVERT(1'b0), .VEL_WINDOW(100)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .count_clear(count_clear),
    .position(position), .step_pulse(step_pulse), .step_dir(step_dir), .quad_err(quad_err),
    .velocity(velocity), .vel_valid(vel_valid)
  );

  quad_encoder_decoder #(.FILTER_CYCLES(F), .DIR_INVERT(1'b1), .VEL_WINDOW(100)) dut_inv (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .count_clear(count_clear),
    .position(inv_position), .step_pulse(inv_step_pulse), .step_dir(inv_step_dir),
    .quad_err(inv_quad_err), .velocity(inv_velocity), .vel_valid(inv_vel_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pos;
    logic        dir;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          pushes = 0;
  int          pulses_seen = 0;
  int          vv_seen = 0;
  int          phase = 0;
  logic [1:0]  gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int          g;
  logic [31:0] mpos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_index(input int idx);
    {enc_a, enc_b} = gray_tbl[idx & 3];
  endtask

  // One legal encoder move of d (+1 forward, -1 reverse), held for hold cycles.
  task automatic step(input int d, input int hold);
    exp_t e;
    g = (g + d) & 3;
    drive_index(g);
    mpos  = mpos + 32'(d);
    e.pos = mpos;
    e.dir = (d > 0);
    exp_q.push_back(e);
    pushes++;
    repeat (hold) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d steps still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every step_pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (vel_valid) vv_seen++;
      if (step_pulse) begin
        pulses_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_step_pulse: position %h with no step pending (phase %0d)",
                   position, phase);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("step_position", position, e.pos);
          check("step_dir", {31'd0, step_dir}, {31'd0, e.dir});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset       = 1'b1;
    count_clear = 1'b0;
    g           = 2;
    mpos        = 32'd0;
    drive_index(g);
    repeat (3) @(negedge clk);
    check("reset_position", position, 32'd0);
    check("reset_quad_err", {31'd0, quad_err}, 32'd0);
    check("reset_step_dir", {31'd0, step_dir}, 32'd0);
    check("reset_step_pulse", {31'd0, step_pulse}, 32'd0);

    // Pins at 11 out of reset must not count or flag once SETTLE ends.
    phase = 1;
    reset = 1'b0;
    repeat (F + 3) @(negedge clk);
    check("settle_position", position, 32'd0);
    repeat (20) @(negedge clk);
    check("settle_quad_err", {31'd0, quad_err}, 32'd0);
    check("settle_position_late", position, 32'd0);

    phase = 2;
    repeat (1000) step(1, 10);
    wait_idle();
    check("fwd1000_position", position, 32'd1000);
    check("fwd1000_step_dir", {31'd0, step_dir}, 32'd1);
    check("fwd1000_inv_position", inv_position, 32'hFFFF_FC18);
    check("fwd1000_pulses", 32'(pulses_seen), 32'd1000);

    phase = 3;
    repeat (300) step(($urandom_range(0, 1) == 1) ? 1 : -1, $urandom_range(6, 14));
    wait_idle();
    check("random_position", position, mpos);
    check("random_inv_position", inv_position, -mpos);
    check("random_quad_err", {31'd0, quad_err}, 32'd0);

    // Glitch shorter than the filter must be ignored.
    phase = 4;
    drive_index(g + 1);
    repeat (F - 1) @(negedge clk);
    drive_index(g);
    repeat (20) @(negedge clk);
    check("glitch_position", position, mpos);

    // Clean step: count appears at edge F+3 after the first sampling edge.
    phase = 5;
    step(1, 0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (step_pulse) begin
        lat = n;
        break;
      end
    end
    check("step_latency", 32'(lat), 32'(F + 3));
    @(negedge clk);
    wait_idle();

    // Signed wrap at the positive limit, both directions.
    phase = 6;
    dut.position = 32'h7FFF_FFFF;
    mpos         = 32'h7FFF_FFFF;
    step(1, 10);
    wait_idle();
    check("wrap_up_position", position, 32'h8000_0000);
    step(-1, 10);
    wait_idle();
    check("wrap_down_position", position, 32'h7FFF_FFFF);

    // Both bits change: flag sticks, position holds.
    phase = 7;
    g = (g + 2) & 3;
    drive_index(g);
    repeat (15) @(negedge clk);
    check("err_quad_err", {31'd0, quad_err}, 32'd1);
    check("err_position", position, mpos);

    // One-cycle clear coincident with a step: step discarded, flag cleared.
    phase = 8;
    g = (g + 1) & 3;
    drive_index(g);
    repeat (F + 2) @(negedge clk);
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    mpos = 32'd0;
    repeat (15) @(negedge clk);
    check("clear_position", position, 32'd0);
    check("clear_quad_err", {31'd0, quad_err}, 32'd0);
    step(1, 10);
    wait_idle();
    check("after_clear_position", position, 32'd1);

    phase = 9;
    check("total_pulses", 32'(pulses_seen), 32'(pushes));
`ifndef QUAD_VELOCITY_EN
    check("vel_valid_pulses", 32'(vv_seen), 32'd0);
    check("velocity_tied", velocity, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
